nios_wallet_rng_ctrl: RTL and testbench
=======================================

# nios_wallet_rng_ctrl

Sampling and buffering controller for the wallet's raw entropy input. It samples a 32-bit random source at a programmable rate and runs a repetition-count health test on every sample. Passing samples go into an 8-deep FIFO, which the Nios II drains through an Avalon-MM slave with read latency 1. It sits between the TRNG/ring-oscillator source and the CPU data bus, and replaces direct polling of the raw input port.

## Interface
- DEPTH, 8: FIFO depth in words; power of two.
- REP_LIMIT, 4: consecutive identical samples that trigger a health fault; ≥2.
- clk  in  1  system clock.
- reset_n  in  1  reset; asynchronous, active-low.
- address  in  2  register select: 0 DATA, 1 STATUS, 2 CONTROL, 3 DIV.
- read  in  1  Avalon read strobe.
- write  in  1  Avalon write strobe.
- writedata  in  32  write data.
- in_port  in  32  raw entropy word; already synchronised, stable for at least one clk.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt = irq_en & ~empty.

## Operation
- Register map:
  - CONTROL (RW): bit0 enable, bit1 irq_en, bit2 clear. clear is write-1, self-clearing, and always reads 0.
  - DIV (RW): bits[15:0] sample divider; upper bits read 0.
  - STATUS (RO): [3:0] level, [8] empty, [9] full, [10] underflow (sticky), [11] fault (sticky).
  - DATA (RO): each read pops one word.
- Sample tick:
  - 16-bit counter runs 0..DIV while enable=1 and fault=0; the tick fires when the counter equals DIV.
  - Period is DIV+1 cycles; DIV=0 samples every cycle.
  - Counter holds at 0 while disabled or faulted.
  - Writing DIV restarts the counter at 0.
- Health test, evaluated on every tick:
  - If in_port equals the previous sample, rep_cnt increments; otherwise rep_cnt resets to 1 and prev is updated.
  - When rep_cnt would reach REP_LIMIT: set fault, do not push that sample, stop sampling.
  - Samples before the limit is reached are pushed normally.
- Push: on a passing tick. If the FIFO is full the sample is dropped; level, flags and the counter are unaffected.
- Pop: a read of DATA while not empty returns the head word and decrements level.
- Read of DATA while empty: returns 0 and sets underflow.
- Same-cycle push and pop: both happen and level is unchanged.
- Pop-on-empty in the same cycle as a push: the read returns 0, underflow is set, the push completes, and level becomes 1.
- Reading STATUS, CONTROL or DIV has no side effects.
- clear:
  - flushes the FIFO (level 0);
  - clears underflow and fault;
  - resets rep_cnt to 0 and invalidates prev;
  - restarts the counter.
  - A clear takes priority over a push or pop in the same cycle.
  - The enable and irq_en bits from the same write apply normally.
- Simultaneous read and write: not possible on Avalon; if both strobes are asserted, the write is honoured and readdata is unchanged.

## Timing
- All outputs reset to 0: readdata=0, irq=0.
- Register reset values: enable=0, irq_en=0, DIV=0, FIFO empty, underflow=0, fault=0, rep_cnt=0.
- Read latency 1: readdata is valid in the cycle after read is sampled high and holds until the next read.
- A write takes effect in the following cycle. After enable is set by a write in cycle N, the first tick occurs in cycle N+1+DIV.
- A pushed word is visible in STATUS.level and poppable one cycle after its tick.
- irq is combinational from registered state; it deasserts the cycle after the last word is popped.
- Asynchronous reset mid-operation discards FIFO contents and every state bit immediately.

## Structure
- Package nios_wallet_rng_pkg holds:
  - register address constants;
  - CONTROL and STATUS bit positions;
  - the DIV width (16).
- Sub-module nios_wallet_rng_fifo:
  - synchronous FIFO of DEPTH×32 with push, pop, clear, dout (head, show-ahead), level, empty and full;
  - wrap-around pointers of log2(DEPTH)+1 bits.
- The top level holds the Avalon decode, the divider, the health test, sticky flags and the readdata register.

## Test plan
- Reset, then read all four registers → readdata 0 each; STATUS=0x100 (empty). irq=0.
- DIV=3, enable=1, in_port incrementing each cycle → ticks every 4 cycles; 8 words fill FIFO; STATUS.full=1, level=8; further samples dropped; DATA reads return the 8 sampled values in order.
- Drain to empty, then read DATA once more → readdata 0, STATUS.underflow=1. Write clear → underflow=0.
- DIV=0, in_port held at 0xDEADBEEF, REP_LIMIT=4 → exactly 3 words pushed; fault=1; sampling stops. Write clear plus enable → sampling resumes.
- With level=1, DATA read in the same cycle as a tick → pop and push both happen, level stays 1. With level=0, same coincidence → readdata 0, underflow=1, level=1.
- irq_en=1: irq rises the cycle after the first push and falls the cycle after the pop that empties the FIFO. Reset asserted mid-fill → level 0 and irq 0 immediately.

Source files
------------

// File: rtl/nios_wallet_rng_pkg.sv
// nios_wallet_rng_pkg: register map, bit positions and widths shared by the entropy sampler
package nios_wallet_rng_pkg;
  localparam int DIV_W = 16;
  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,
    REG_STATUS  = 2'd1,
    REG_CONTROL = 2'd2,
    REG_DIV     = 2'd3
  } reg_addr_t;
  localparam int CTRL_ENABLE  = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_CLEAR   = 2;
  localparam int ST_EMPTY     = 8;
  localparam int ST_FULL      = 9;
  localparam int ST_UNDERFLOW = 10;
  localparam int ST_FAULT     = 11;
endpackage

// File: rtl/nios_wallet_rng_fifo.sv
// nios_wallet_rng_fifo: show-ahead synchronous FIFO with wrap-bit pointers and priority clear
module nios_wallet_rng_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [AW:0]   level,
  output logic          empty,
  output logic          full
);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign level = wr_ptr - rd_ptr;
  assign empty = level == '0;
  assign full = level == (AW+1)'(DEPTH);
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign dout = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/nios_wallet_rng_ctrl.sv
// nios_wallet_rng_ctrl: rate-divided entropy sampler with repetition-count health test and Avalon FIFO
module nios_wallet_rng_ctrl
  import nios_wallet_rng_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int REP_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [31:0] in_port,
  output logic [31:0] readdata,
  output logic        irq
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int RW = $clog2(REP_LIMIT + 1);
  logic enable, irq_en, underflow, fault, prev_valid;
  logic [DIV_W-1:0] div, cnt;
  logic [31:0] prev, dout, status, ctrl, rd_mux;
  logic [RW-1:0] rep_cnt, rep_next;
  logic [LW-1:0] level;
  logic empty, full, rd_en, ctrl_wr, div_wr, data_rd, clear, tick, trip, push, pop;
  assign rd_en = read & ~write;
  assign ctrl_wr = write && address == REG_CONTROL;
  assign div_wr = write && address == REG_DIV;
  assign data_rd = rd_en && address == REG_DATA;
  assign clear = ctrl_wr & writedata[CTRL_CLEAR];
  assign tick = enable & ~fault & (cnt == div);
  assign rep_next = (prev_valid && in_port == prev) ? rep_cnt + RW'(1) : RW'(1);
  // the sample that would hit the limit is withheld from the FIFO
  assign trip = tick && rep_next == RW'(REP_LIMIT);
  assign push = tick & ~trip;
  assign pop = data_rd & ~empty;
  assign irq = irq_en & ~empty;
  nios_wallet_rng_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
    .clk(clk), .reset_n(reset_n), .push(push), .pop(pop), .clear(clear),
    .din(in_port), .dout(dout), .level(level), .empty(empty), .full(full)
  );
  always_comb begin
    status = '0;
    status[LW-1:0] = level;
    status[ST_EMPTY] = empty;
    status[ST_FULL] = full;
    status[ST_UNDERFLOW] = underflow;
    status[ST_FAULT] = fault;
    ctrl = '0;
    ctrl[CTRL_ENABLE] = enable;
    ctrl[CTRL_IRQ_EN] = irq_en;
    rd_mux = address == REG_DATA ? (empty ? '0 : dout) :
             address == REG_STATUS ? status :
             address == REG_CONTROL ? ctrl : 32'(div);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      enable <= 1'b0;
      irq_en <= 1'b0;
      div <= '0;
      cnt <= '0;
      underflow <= 1'b0;
      fault <= 1'b0;
      rep_cnt <= '0;
      prev <= '0;
      prev_valid <= 1'b0;
      readdata <= '0;
    end else begin
      if (ctrl_wr) begin
        enable <= writedata[CTRL_ENABLE];
        irq_en <= writedata[CTRL_IRQ_EN];
      end
      if (div_wr) div <= writedata[DIV_W-1:0];
      cnt <= (clear || div_wr || !enable || fault || tick) ? '0 : cnt + DIV_W'(1);
      if (clear) begin
        underflow <= 1'b0;
        fault <= 1'b0;
        rep_cnt <= '0;
        prev_valid <= 1'b0;
      end else begin
        if (data_rd && empty) underflow <= 1'b1;
        if (trip) fault <= 1'b1;
        if (push) begin
          rep_cnt <= rep_next;
          prev <= in_port;
          prev_valid <= 1'b1;
        end
      end
      if (rd_en) readdata <= rd_mux;
    end
endmodule

// File: tb/tb_nios_wallet_rng_ctrl.sv
// tb_nios_wallet_rng_ctrl: directed scenarios for the entropy sampler with hand-computed expectations
module tb_nios_wallet_rng_ctrl;
  logic clk = 0, reset_n = 0, read = 0, write = 0, irq;
  logic [1:0] address = 0;
  logic [31:0] writedata = 0, in_port = 0, readdata, d;
  int total = 0, bad = 0;
  bit inc = 0;
  always #5 clk = ~clk;
  nios_wallet_rng_ctrl #(.DEPTH(8), .REP_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .in_port(in_port), .readdata(readdata), .irq(irq)
  );
  task automatic step();
    @(negedge clk);
    if (inc) in_port = in_port + 32'd1;
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    step();
    address = a;
    writedata = v;
    write = 1;
    step();
    write = 0;
  endtask
  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    step();
    address = a;
    read = 1;
    step();
    read = 0;
    v = readdata;
  endtask
  task automatic test_reset();
    reset_n = 0;
    repeat (3) @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
    total++; if (readdata !== 32'h0) begin bad++; $display("FAIL reset_readdata got=%h exp=0", readdata); end
    reset_n = 1;
    rd(2'd1, d); total++; if (d !== 32'h100) begin bad++; $display("FAIL reset_status got=%h exp=100", d); end
    rd(2'd2, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_control got=%h exp=0", d); end
    rd(2'd3, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_div got=%h exp=0", d); end
    rd(2'd0, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", d); end
    wr(2'd2, 32'h4);
  endtask
  task automatic test_fill();
    wr(2'd3, 32'd3);
    rd(2'd3, d); total++; if (d !== 32'd3) begin bad++; $display("FAIL div_readback got=%h exp=3", d); end
    in_port = 0;
    inc = 1;
    wr(2'd2, 32'h1);
    repeat (40) step();
    inc = 0;
    wr(2'd2, 32'h0);
    rd(2'd1, d); total++; if (d !== 32'h208) begin bad++; $display("FAIL fill_status got=%h exp=208", d); end
    for (int k = 0; k < 8; k++) begin
      rd(2'd0, d);
      total++; if (d !== 32'(5 + 4 * k)) begin bad++; $display("FAIL fill_data%0d got=%h exp=%h", k, d, 32'(5 + 4 * k)); end
    end
  endtask
  task automatic test_underflow();
    rd(2'd0, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL under_data got=%h exp=0", d); end
    rd(2'd1, d); total++; if (d !== 32'h500) begin bad++; $display("FAIL under_status got=%h exp=500", d); end
    wr(2'd2, 32'h4);
    rd(2'd1, d); total++; if (d !== 32'h100) begin bad++; $display("FAIL under_clear got=%h exp=100", d); end
    rd(2'd2, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL clear_reads0 got=%h exp=0", d); end
  endtask
  task automatic test_fault();
    in_port = 32'hDEADBEEF;
    wr(2'd3, 32'd0);
    wr(2'd2, 32'h1);
    repeat (10) step();
    rd(2'd1, d); total++; if (d !== 32'h803) begin bad++; $display("FAIL fault_status got=%h exp=803", d); end
    rd(2'd0, d); total++; if (d !== 32'hDEADBEEF) begin bad++; $display("FAIL fault_data got=%h exp=deadbeef", d); end
    repeat (5) step();
    rd(2'd1, d); total++; if (d !== 32'h802) begin bad++; $display("FAIL fault_stopped got=%h exp=802", d); end
    inc = 1;
    wr(2'd2, 32'h5);
    rd(2'd1, d); total++; if (d !== 32'h001) begin bad++; $display("FAIL fault_resume got=%h exp=1", d); end
    inc = 0;
    wr(2'd2, 32'h4);
    rd(2'd1, d); total++; if (d !== 32'h100) begin bad++; $display("FAIL fault_flush got=%h exp=100", d); end
  endtask
  task automatic test_coincide();
    wr(2'd3, 32'd3);
    in_port = 32'hA5A50001;
    wr(2'd2, 32'h1);
    repeat (4) step();
    in_port = 32'hA5A50002;
    repeat (2) step();
    rd(2'd0, d); total++; if (d !== 32'hA5A50001) begin bad++; $display("FAIL pushpop_data got=%h exp=a5a50001", d); end
    wr(2'd2, 32'h0);
    rd(2'd1, d); total++; if (d !== 32'h001) begin bad++; $display("FAIL pushpop_level got=%h exp=1", d); end
    rd(2'd0, d); total++; if (d !== 32'hA5A50002) begin bad++; $display("FAIL pushpop_second got=%h exp=a5a50002", d); end
    in_port = 32'hC0FFEE00;
    wr(2'd2, 32'h1);
    repeat (2) step();
    rd(2'd0, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL emptypop_data got=%h exp=0", d); end
    wr(2'd2, 32'h0);
    rd(2'd1, d); total++; if (d !== 32'h401) begin bad++; $display("FAIL emptypop_status got=%h exp=401", d); end
    rd(2'd0, d); total++; if (d !== 32'hC0FFEE00) begin bad++; $display("FAIL emptypop_word got=%h exp=c0ffee00", d); end
    wr(2'd2, 32'h4);
  endtask
  task automatic test_irq();
    in_port = 32'h12345678;
    wr(2'd2, 32'h3);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_idle got=%b exp=0", irq); end
    repeat (3) step();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_pretick got=%b exp=0", irq); end
    step();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_rise got=%b exp=1", irq); end
    wr(2'd2, 32'h2);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_hold got=%b exp=1", irq); end
    rd(2'd0, d); total++; if (d !== 32'h12345678) begin bad++; $display("FAIL irq_data got=%h exp=12345678", d); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_fall got=%b exp=0", irq); end
  endtask
  task automatic test_async_reset();
    wr(2'd2, 32'h3);
    repeat (6) step();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL midfill_irq got=%b exp=1", irq); end
    #2 reset_n = 0;
    #1;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL areset_irq got=%b exp=0", irq); end
    total++; if (readdata !== 32'h0) begin bad++; $display("FAIL areset_readdata got=%h exp=0", readdata); end
    @(negedge clk);
    reset_n = 1;
    rd(2'd1, d); total++; if (d !== 32'h100) begin bad++; $display("FAIL areset_status got=%h exp=100", d); end
    rd(2'd2, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL areset_control got=%h exp=0", d); end
    rd(2'd3, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL areset_div got=%h exp=0", d); end
  endtask
  initial begin
    test_reset();
    test_fill();
    test_underflow();
    test_fault();
    test_coincide();
    test_irq();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
